// File: rtl/prog_mem_loader_if.sv
// Boot-load bus: sequencer control, UART byte stream and program-memory write port.
// The loader takes the slave view; the sequencer/UART side takes the master view.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              write;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              write_done;
    logic              load_error;
    logic [ADDR_W:0]   word_count;

    modport slave (
        input  write, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, write_done, load_error, word_count
    );

    modport master (
        output write, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, write_done, load_error, word_count
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program-memory loader: parses a little-endian word-count header from the UART
// byte stream, then writes N assembled 32-bit words to consecutive addresses.
module prog_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    prog_mem_loader_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WR, DONE, ERR} state_t;

    // Largest legal word count is the full memory, 2**ADDR_W words.
    localparam logic [32:0] LEN_MAX = 33'd1 << ADDR_W;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     asm_q, asm_d;
    logic [ADDR_W:0] wcnt_q, wcnt_d;

    logic        rx_ready;
    logic        accept;
    logic [31:0] len_full;
    logic [31:0] asm_full;

    // Ready is gated by write so a byte arriving as write falls is never taken.
    assign rx_ready = ((state_q == HDR) || (state_q == DATA)) && bus.write;
    assign accept   = rx_ready && bus.rx_valid;

    always_comb begin
        len_full = len_q;
        len_full[8*idx_q +: 8] = bus.rx_data;
        asm_full = asm_q;
        asm_full[8*idx_q +: 8] = bus.rx_data;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        asm_d   = asm_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.write) begin
                    state_d = HDR;
                    idx_d   = 2'd0;
                    wcnt_d  = '0;
                end
            end
            HDR: begin
                if (!bus.write) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end else if (accept) begin
                    len_d = len_full;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if ((len_full == 32'd0) || ({1'b0, len_full} > LEN_MAX))
                            state_d = ERR;
                        else
                            state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (!bus.write) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end else if (accept) begin
                    asm_d = asm_full;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3)
                        state_d = WR;
                end
            end
            WR: begin
                // The strobe in this cycle always lands, so the count advances even on abort.
                wcnt_d = wcnt_q + 1'b1;
                if (!bus.write)
                    state_d = IDLE;
                else if (wcnt_d == len_q[ADDR_W:0])
                    state_d = DONE;
                else
                    state_d = DATA;
            end
            DONE: begin
                if (!bus.write)
                    state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            len_q   <= '0;
            asm_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Status and strobes decode straight from the state flop so reset clears them at once.
    assign bus.rx_ready   = rx_ready;
    assign bus.mem_we     = (state_q == WR);
    assign bus.mem_addr   = wcnt_q[ADDR_W-1:0];
    assign bus.mem_wdata  = asm_q;
    assign bus.write_done = (state_q == DONE);
    assign bus.load_error = (state_q == ERR);
    assign bus.word_count = wcnt_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: expected memory writes are queued as the
// stream is driven and checked when mem_we fires.
module tb_prog_mem_loader;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", bus.mem_we, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("we_addr", bus.mem_addr, e.addr);
                chk("we_data", bus.mem_wdata, e.data);
            end
        end
    end

    // Called and returns at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int k = 0; k < 50; k++) begin
            if (bus.rx_ready === 1'b1) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("byte_timeout", bus.rx_ready, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit is_data);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
        if (is_data) chk("we_latency", bus.mem_we, 64'd1);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = a[ADDR_W-1:0];
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.write    = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.write    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state, then idle with a byte offered but write low
        @(negedge clk);
        chk("rst_ready", bus.rx_ready, 64'd0);
        chk("rst_we", bus.mem_we, 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("idle_ready", bus.rx_ready, 64'd0);
        chk("idle_done", bus.write_done, 64'd0);
        chk("idle_err", bus.load_error, 64'd0);
        chk("idle_wc", bus.word_count, 64'd0);
        chk("idle_addr", bus.mem_addr, 64'd0);
        chk("idle_wdata", bus.mem_wdata, 64'd0);

        // Two-word load, back-to-back bytes
        bus.write = 1'b1;
        push_wr(0, 32'h12345678);
        push_wr(1, 32'hDEADBEEF);
        send_word(32'd2, 0, 0);
        send_word(32'h12345678, 0, 1);
        send_word(32'hDEADBEEF, 0, 1);
        @(negedge clk);
        chk("b2b_done", bus.write_done, 64'd1);
        chk("b2b_wc", bus.word_count, 64'd2);
        chk("done_ready", bus.rx_ready, 64'd0);
        bus.write = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("b2b_done_drop", bus.write_done, 64'd0);
        chk("b2b_wc_hold", bus.word_count, 64'd2);
        chk("b2b_q_empty", 64'(exp_q.size()), 64'd0);

        // Same stream with 3-cycle valid gaps
        bus.write = 1'b1;
        push_wr(0, 32'h12345678);
        push_wr(1, 32'hDEADBEEF);
        send_word(32'd2, 3, 0);
        send_word(32'h12345678, 3, 1);
        send_word(32'hDEADBEEF, 3, 1);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("gap_done", bus.write_done, 64'd1);
        chk("gap_wc", bus.word_count, 64'd2);
        bus.write = 1'b0;
        @(negedge clk);
        chk("gap_q_empty", 64'(exp_q.size()), 64'd0);

        // Zero-length header
        bus.write = 1'b1;
        send_word(32'd0, 0, 0);
        chk("hdr0_err", bus.load_error, 64'd1);
        chk("hdr0_ready", bus.rx_ready, 64'd0);
        chk("hdr0_done", bus.write_done, 64'd0);
        bus.write = 1'b0;
        repeat (2) @(negedge clk);
        bus.write = 1'b1;
        repeat (2) @(negedge clk);
        chk("hdr0_sticky", bus.load_error, 64'd1);
        chk("hdr0_sticky_ready", bus.rx_ready, 64'd0);
        do_reset();
        chk("hdr0_clear", bus.load_error, 64'd0);

        // Oversized header, 1025 words
        bus.write = 1'b1;
        send_word(32'h0000_0401, 0, 0);
        chk("hdrbig_err", bus.load_error, 64'd1);
        bus.write = 1'b0;
        repeat (2) @(negedge clk);
        chk("hdrbig_sticky", bus.load_error, 64'd1);
        do_reset();
        chk("hdrbig_clear", bus.load_error, 64'd0);

        // Max-length header is accepted (no error after header)
        bus.write = 1'b1;
        send_word(32'h0000_0400, 0, 0);
        chk("hdrmax_ok", bus.load_error, 64'd0);
        chk("hdrmax_ready", bus.rx_ready, 64'd1);
        bus.write = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);

        // Abort mid-word, then restart
        bus.write = 1'b1;
        push_wr(0, 32'h11223344);
        send_word(32'd3, 0, 0);
        send_word(32'h11223344, 0, 1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        bus.write    = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("abort_ready", bus.rx_ready, 64'd0);
        chk("abort_done", bus.write_done, 64'd0);
        chk("abort_wc", bus.word_count, 64'd1);
        chk("abort_q_empty", 64'(exp_q.size()), 64'd0);
        bus.write = 1'b1;
        push_wr(0, 32'hDDCCBBAA);
        send_word(32'd1, 0, 0);
        send_word(32'hDDCCBBAA, 0, 1);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("restart_done", bus.write_done, 64'd1);
        chk("restart_wc", bus.word_count, 64'd1);
        bus.write = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of DATA
        bus.write = 1'b1;
        push_wr(0, 32'h0BADF00D);
        send_word(32'd2, 0, 0);
        send_word(32'h0BADF00D, 0, 1);
        send_byte(8'h01, 0);
        chk("pre_rst_ready", bus.rx_ready, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", bus.rx_ready, 64'd0);
        chk("async_wc", bus.word_count, 64'd0);
        chk("async_we", bus.mem_we, 64'd0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_wr(0, 32'hCAFEF00D);
        send_word(32'd1, 0, 0);
        send_word(32'hCAFEF00D, 0, 1);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_done", bus.write_done, 64'd1);
        chk("post_rst_wc", bus.word_count, 64'd1);
        bus.write = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
